// File: rtl/iobus_pkg.sv
// Shared types and constants for the OTTER I/O bus MMIO hub.
package iobus_pkg;

  localparam logic [31:0] IN_BASE_DEF   = 32'h1100_8000;
  localparam logic [31:0] OUT_BASE_DEF  = 32'h1100_C000;
  localparam logic [31:0] GPU_ADDR_DEF  = 32'h1100_C100;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h1100_8100;

  typedef struct packed {
    logic [11:0] data;
    logic [15:0] addr;
  } gpu_wr_t;

  // Status word layout
  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_LEVEL_W   = 16;
  localparam int STAT_FULL_BIT  = 16;
  localparam int STAT_EMPTY_BIT = 17;
  localparam int STAT_OVF_BIT   = 31;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is taken only
// when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iobus_mmio_hub.sv
// MMIO hub: output register bank, input port read mux, posted VRAM write FIFO.
// Define IOBUS_HUB_STATUS_EN to map the FIFO status/overflow register.
module iobus_mmio_hub
  import iobus_pkg::*;
#(
  parameter int          NUM_OUT    = 8,
  parameter int          OUT_W      = 32,
  parameter int          NUM_IN     = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] IN_BASE    = IN_BASE_DEF,
  parameter logic [31:0] OUT_BASE   = OUT_BASE_DEF,
  parameter logic [31:0] GPU_ADDR   = GPU_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [31:0]              iobus_addr,
  input  logic [31:0]              iobus_out,
  input  logic                     iobus_wr,
  output logic [31:0]              iobus_in,
  input  logic [NUM_IN*32-1:0]     in_ports,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  output logic [NUM_OUT-1:0]       out_strobe,
  output logic                     gpu_valid,
  output logic [15:0]              gpu_addr,
  output logic [11:0]              gpu_data,
  input  logic                     gpu_ready
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]        out_off, in_off;
  logic               aligned, out_hit, in_hit;
  logic [NUM_OUT-1:0] out_we;
  logic               gpu_push, gpu_pop;
  gpu_wr_t            wr_entry, head;
  logic               fifo_full, fifo_empty;
  logic [LW-1:0]      fifo_level;

  assign aligned = (iobus_addr[1:0] == 2'b00);
  assign out_off = iobus_addr - OUT_BASE;
  assign in_off  = iobus_addr - IN_BASE;
  assign out_hit = aligned && (out_off[1:0] == 2'b00) && (out_off < 32'(4 * NUM_OUT));
  assign in_hit  = aligned && (in_off[1:0] == 2'b00) && (in_off < 32'(4 * NUM_IN));

  always_comb begin
    out_we = '0;
    for (int k = 0; k < NUM_OUT; k++)
      out_we[k] = iobus_wr && out_hit && (out_off[31:2] == 30'(k));
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      out_regs   <= '0;
      out_strobe <= '0;
    end else begin
      out_strobe <= out_we;
      for (int k = 0; k < NUM_OUT; k++)
        if (out_we[k]) out_regs[OUT_W*k +: OUT_W] <= iobus_out[OUT_W-1:0];
    end
  end

  assign gpu_push = iobus_wr && (iobus_addr == GPU_ADDR);
  assign gpu_pop  = gpu_valid && gpu_ready;
  assign wr_entry = '{data: iobus_out[27:16], addr: iobus_out[15:0]};

  sync_fifo #(
    .WIDTH ($bits(gpu_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (gpu_push),
    .din   (wr_entry),
    .pop   (gpu_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Head storage is unreset, so mask it while nothing is queued.
  assign gpu_valid = !fifo_empty;
  assign gpu_addr  = fifo_empty ? 16'h0 : head.addr;
  assign gpu_data  = fifo_empty ? 12'h0 : head.data;

`ifdef IOBUS_HUB_STATUS_EN
  logic        ovf, stat_hit;
  logic [31:0] stat_word;

  assign stat_hit = aligned && (iobus_addr == STAT_ADDR);

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge RST) begin
    if (RST)                                  ovf <= 1'b0;
    else if (gpu_push && fifo_full && !gpu_pop) ovf <= 1'b1;
    else if (iobus_wr && stat_hit)            ovf <= 1'b0;
  end

  always_comb begin
    stat_word = '0;
    stat_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    stat_word[STAT_FULL_BIT]  = fifo_full;
    stat_word[STAT_EMPTY_BIT] = fifo_empty;
    stat_word[STAT_OVF_BIT]   = ovf;
  end
`endif

  always_comb begin
    iobus_in = '0;
    if (in_hit)
      for (int k = 0; k < NUM_IN; k++)
        if (in_off[31:2] == 30'(k)) iobus_in = in_ports[32*k +: 32];
`ifdef IOBUS_HUB_STATUS_EN
    if (stat_hit) iobus_in = stat_word;
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{iobus_out, fifo_level, STAT_ADDR};

endmodule

// File: tb/tb_iobus_mmio_hub.sv
// Randomized and directed bench for iobus_mmio_hub against a queue-based model.
module tb_iobus_mmio_hub;
  import iobus_pkg::*;

  localparam int NUM_OUT = 8;
  localparam int OUT_W   = 32;
  localparam int NUM_IN  = 4;
  localparam int DEPTH   = 16;
  localparam logic [31:0] INB   = 32'h1100_8000;
  localparam logic [31:0] OUTB  = 32'h1100_C000;
  localparam logic [31:0] GPUA  = 32'h1100_C100;
  localparam logic [31:0] STATA = 32'h1100_8100;
`ifdef IOBUS_HUB_STATUS_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     RST = 1'b1;
  logic [31:0]              iobus_addr, iobus_out, iobus_in;
  logic                     iobus_wr, gpu_ready, gpu_valid;
  logic [NUM_IN*32-1:0]     in_ports;
  logic [NUM_OUT*OUT_W-1:0] out_regs;
  logic [NUM_OUT-1:0]       out_strobe;
  logic [15:0]              gpu_addr;
  logic [11:0]              gpu_data;

  always #10 clk = ~clk;

  iobus_mmio_hub #(
    .NUM_OUT(NUM_OUT), .OUT_W(OUT_W), .NUM_IN(NUM_IN), .FIFO_DEPTH(DEPTH),
    .IN_BASE(INB), .OUT_BASE(OUTB), .GPU_ADDR(GPUA), .STAT_ADDR(STATA)
  ) dut (
    .clk(clk), .RST(RST), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
    .iobus_wr(iobus_wr), .iobus_in(iobus_in), .in_ports(in_ports),
    .out_regs(out_regs), .out_strobe(out_strobe), .gpu_valid(gpu_valid),
    .gpu_addr(gpu_addr), .gpu_data(gpu_data), .gpu_ready(gpu_ready)
  );

  int total = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: queue of pushed words, array of register values.
  logic [27:0]        q[$];
  logic [31:0]        m_out[NUM_OUT];
  logic [NUM_OUT-1:0] m_strb;
  bit                 m_ovf;
  logic [15:0]        pops[$];

  always @(posedge clk or posedge RST) begin
    int  n, idx;
    bit  pop, push, drop;
    if (RST) begin
      q.delete();
      for (int i = 0; i < NUM_OUT; i++) m_out[i] = '0;
      m_strb = '0;
      m_ovf  = 1'b0;
    end else begin
      n    = q.size();
      pop  = (n > 0) && gpu_ready;
      push = iobus_wr && (iobus_addr == GPUA);
      drop = push && (n == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(iobus_out[27:0]);
      m_strb = '0;
      if (iobus_wr && iobus_addr[1:0] == 2'b00 && iobus_addr >= OUTB &&
          iobus_addr < OUTB + 32'(4 * NUM_OUT)) begin
        idx = int'((iobus_addr - OUTB) >> 2);
        m_out[idx]  = iobus_out;
        m_strb[idx] = 1'b1;
      end
      if (STAT_ON) begin
        if (drop) m_ovf = 1'b1;
        else if (iobus_wr && iobus_addr == STATA) m_ovf = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int idx;
    if (a[1:0] != 2'b00) return 32'h0;
    if (a >= INB && a < INB + 32'(4 * NUM_IN)) begin
      idx = int'((a - INB) >> 2);
      return in_ports[32*idx +: 32];
    end
    if (STAT_ON && a == STATA)
      return {m_ovf, 13'h0, q.size() == 0, q.size() == DEPTH, 16'(q.size())};
    return 32'h0;
  endfunction

  // Compare process: every falling edge once out of the initial reset.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NUM_OUT; k++)
        chk("out_reg", 64'(out_regs[32*k +: 32]), 64'(m_out[k]));
      chk("out_strobe", 64'(out_strobe), 64'(m_strb));
      chk("gpu_valid", 64'(gpu_valid), 64'(q.size() != 0));
      chk("gpu_addr", 64'(gpu_addr), 64'(q.size() != 0 ? q[0][15:0] : 16'h0));
      chk("gpu_data", 64'(gpu_data), 64'(q.size() != 0 ? q[0][27:16] : 12'h0));
      chk("iobus_in", 64'(iobus_in), 64'(exp_read(iobus_addr)));
      if (gpu_valid && gpu_ready) pops.push_back(gpu_addr);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit w, input bit rdy);
    @(posedge clk);
    #2;
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = w;
    gpu_ready  = rdy;
  endtask

  initial begin
    int cnt;
    int r;
    logic [31:0] a;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    gpu_ready  = 1'b0;
    in_ports   = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    #1;
    chk("rst_valid", 64'(gpu_valid), 64'(0));
    chk("rst_strobe", 64'(out_strobe), 64'(0));
    chk("rst_regs", 64'(|out_regs), 64'(0));
    chk("rst_gpu_addr", 64'(gpu_addr), 64'(0));
    repeat (3) @(posedge clk);
    #2 RST = 1'b0;
    chk_en = 1'b1;

    drive(INB + 32'd8, 0, 0, 0);
    #1 chk("rd_in2", 64'(iobus_in), 64'(32'hDEAD_BEEF));
    drive(32'h1100_8002, 0, 0, 0);
    #1 chk("rd_unaligned", 64'(iobus_in), 64'(0));

    drive(OUTB + 32'd4, 32'h0000_00A5, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("out1_val", 64'(out_regs[63:32]), 64'(32'hA5));
    chk("out1_strobe", 64'(out_strobe), 64'(8'b0000_0010));
    chk("out_others", 64'(|{out_regs[255:64], out_regs[31:0]}), 64'(0));
    @(negedge clk);
    chk("out1_strobe_end", 64'(out_strobe), 64'(0));

    for (int i = 0; i < 16; i++) drive(GPUA, {4'h0, 12'(i), 16'(i)}, 1, 0);
    drive(GPUA, 32'h0999_0099, 1, 0);
    drive(STATA, 0, 0, 0);
    #1 chk("stat_ovf", 64'(iobus_in), 64'(STAT_ON ? 32'h8001_0010 : 32'h0));
    drive(STATA, 0, 1, 0);
    drive(STATA, 0, 0, 0);
    #1 chk("stat_clr", 64'(iobus_in), 64'(STAT_ON ? 32'h0001_0010 : 32'h0));

    pops.delete();
    drive(GPUA, 32'h00AB_00CD, 1, 1);
    drive(STATA, 0, 0, 0);
    #1 chk("stat_full_pp", 64'(iobus_in), 64'(STAT_ON ? 32'h0001_0010 : 32'h0));
    repeat (20) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("drain_cnt", 64'(pops.size()), 64'(17));
    if (pops.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("drain_order", 64'(pops[i]), 64'(i));
      chk("drain_last", 64'(pops[16]), 64'(16'h00CD));
    end

    drive(GPUA, 32'h0123_4567, 1, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      @(negedge clk);
      if (i == 0) begin
        chk("push_lat", 64'(gpu_valid), 64'(1));
        chk("push_data", 64'({gpu_data, gpu_addr}), 64'(28'h123_4567));
      end
      if (gpu_valid) cnt++;
    end
    chk("valid_1cyc", 64'(cnt), 64'(1));

    drive(OUTB, 32'h77, 1, 0);
    for (int i = 0; i < 5; i++) drive(GPUA, 32'h0050_1000 + 32'(i), 1, 0);
    drive(0, 0, 0, 1);
    #3 RST = 1'b1;
    iobus_addr = STATA;
    #1;
    chk("rst_mid_valid", 64'(gpu_valid), 64'(0));
    chk("rst_mid_addr", 64'(gpu_addr), 64'(0));
    chk("rst_mid_regs", 64'(|out_regs), 64'(0));
    chk("rst_mid_stat", 64'(iobus_in), 64'(STAT_ON ? 32'h0002_0000 : 32'h0));
    @(posedge clk);
    #2 RST = 1'b0;
    repeat (3) drive(0, 0, 0, 1);
    @(negedge clk);
    chk("rst_no_pop", 64'(gpu_valid), 64'(0));

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: a = GPUA;
        3, 4:    a = OUTB + 32'(4 * $urandom_range(0, 9));
        5:       a = INB + 32'(4 * $urandom_range(0, 5));
        6:       a = STATA;
        7:       a = OUTB + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
        8:       a = INB + 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      in_ports = {$urandom, $urandom, $urandom, $urandom};
      drive(a, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < (((n / 100) % 2) != 0 ? 15 : 80));
    end
    drive(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
